// File: rtl/lm96570_spi_master_if.sv
// Avalon-MM register bus for the LM96570 SPI transmitter.
// The slave modport is the view taken by lm96570_spi_master; master is the
// view of whatever drives the register bus.
interface lm96570_spi_master_if;
    logic [1:0]  address;
    logic        write;
    logic [31:0] writedata;
    logic [31:0] readdata;

    modport slave  (input  address, input  write, input  writedata, output readdata);
    modport master (output address, output write, output writedata, input  readdata);
endinterface

// File: rtl/lm96570_spi_master.sv
// LM96570 serial configuration transmitter (SCLK/SDI/SLE) with SDO capture.
// Registers: 0 TXDATA, 1 CTRL (NBITS, MSB_FIRST, START, IRQ_EN), 2 STATUS
// (BUSY, sticky DONE), 3 RXDATA. Optional completion interrupt is built only
// when the macro LM96570_SPI_IRQ_EN is defined.
module lm96570_spi_master #(
    parameter int unsigned CLK_DIV   = 4,
    parameter int unsigned SCLK_IDLE = 0
) (
    input  logic                       clk,
    input  logic                       reset_n,
    lm96570_spi_master_if.slave        avs,
    output logic                       spi_sclk,
    output logic                       spi_sdi,
    output logic                       spi_sle,
    input  logic                       spi_sdo
`ifdef LM96570_SPI_IRQ_EN
    ,
    output logic                       irq
`endif
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_SHIFT_LO,
        S_SHIFT_HI,
        S_LATCH
    } state_t;

    localparam logic [7:0] DIV_RELOAD = 8'(CLK_DIV - 1);

    state_t      r_state;
    state_t      w_state_next;
    logic [31:0] r_txdata;
    logic [31:0] r_shift;
    logic [31:0] r_rxdata;
    logic [5:0]  r_nbits;
    logic        r_msb_first;
    logic        r_done;
    logic [4:0]  r_bitidx;
    logic [4:0]  r_last_idx;
    logic [7:0]  r_div;
    logic [1:0]  r_sdo_sync;

    logic        w_busy;
    logic        w_div_done;
    logic        w_last_bit;
    logic        w_wr_tx;
    logic        w_wr_ctrl;
    logic        w_wr_status;
    logic        w_start;
    logic        w_done_set;
    logic        w_first_hi;
    logic        w_advance;
    logic        w_cur_bit;
    logic        w_irq_en_rd;
    logic [5:0]  w_nbits_m1;
    logic [4:0]  w_load_last;
    logic        w_unused_sclk_idle;

    // Only an idle-low SCLK is implemented.
    assign w_unused_sclk_idle = (SCLK_IDLE != 0);

    assign w_busy      = (r_state != S_IDLE);
    assign w_div_done  = (r_div == 8'd0);
    assign w_last_bit  = (r_bitidx == r_last_idx);
    assign w_wr_tx     = avs.write && (avs.address == 2'd0) && !w_busy;
    assign w_wr_ctrl   = avs.write && (avs.address == 2'd1) && !w_busy;
    assign w_wr_status = avs.write && (avs.address == 2'd2);
    assign w_start     = w_wr_ctrl && avs.writedata[9];
    assign w_done_set  = (r_state == S_LATCH) && w_div_done;
    assign w_first_hi  = (r_state == S_SHIFT_HI) && (r_div == DIV_RELOAD);
    assign w_advance   = (r_state == S_SHIFT_HI) && w_div_done && !w_last_bit;
    assign w_cur_bit   = r_msb_first ? r_shift[31] : r_shift[0];
    // NBITS of 0 wraps to index 31, i.e. a 32-bit word.
    assign w_nbits_m1  = avs.writedata[5:0] - 6'd1;
    assign w_load_last = w_nbits_m1[4:0];

    // State register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state logic and serial line decode.
    always_comb begin
        w_state_next = r_state;
        spi_sclk     = 1'b0;
        spi_sle      = 1'b0;
        spi_sdi      = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_start) w_state_next = S_SHIFT_LO;
            end
            S_SHIFT_LO: begin
                spi_sdi = w_cur_bit;
                if (w_div_done) w_state_next = S_SHIFT_HI;
            end
            S_SHIFT_HI: begin
                spi_sclk = 1'b1;
                spi_sdi  = w_cur_bit;
                if (w_div_done) w_state_next = w_last_bit ? S_LATCH : S_SHIFT_LO;
            end
            S_LATCH: begin
                spi_sle = 1'b1;
                spi_sdi = w_cur_bit;
                if (w_div_done) w_state_next = S_IDLE;
            end
            default: w_state_next = S_IDLE;
        endcase
    end

    // Phase divider: reloads on every state entry, counts down to zero.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_div <= '0;
        end else if (w_state_next != r_state) begin
            r_div <= DIV_RELOAD;
        end else if (!w_div_done) begin
            r_div <= r_div - 8'd1;
        end
    end

    // Two-flop synchroniser for the LM96570 readback line.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_sdo_sync <= '0;
        end else begin
            r_sdo_sync <= {r_sdo_sync[0], spi_sdo};
        end
    end

    // Register file, shift/capture datapath and DONE flag.
    // MSB-first words are pre-aligned to bit 31 at load so the active bit is
    // always at a fixed end of the shift register in either order.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_txdata    <= '0;
            r_shift     <= '0;
            r_rxdata    <= '0;
            r_nbits     <= '0;
            r_msb_first <= 1'b0;
            r_done      <= 1'b0;
            r_bitidx    <= '0;
            r_last_idx  <= '0;
        end else begin
            if (w_wr_tx) r_txdata <= avs.writedata;
            if (w_wr_ctrl) begin
                r_nbits     <= avs.writedata[5:0];
                r_msb_first <= avs.writedata[8];
            end
            if (w_start) begin
                r_shift    <= avs.writedata[8] ? (r_txdata << (5'd31 - w_load_last)) : r_txdata;
                r_bitidx   <= '0;
                r_last_idx <= w_load_last;
                r_rxdata   <= '0;
                r_done     <= 1'b0;
            end else begin
                if (w_first_hi) begin
                    if (r_msb_first) r_rxdata <= {r_rxdata[30:0], r_sdo_sync[1]};
                    else             r_rxdata[r_bitidx] <= r_sdo_sync[1];
                end
                if (w_advance) begin
                    r_shift  <= r_msb_first ? {r_shift[30:0], 1'b0} : {1'b0, r_shift[31:1]};
                    r_bitidx <= r_bitidx + 5'd1;
                end
            end
            if (w_wr_status && avs.writedata[1]) r_done <= 1'b0;
            if (w_done_set) r_done <= 1'b1;
        end
    end

`ifdef LM96570_SPI_IRQ_EN
    logic r_irq_en;

    // Interrupt enable: writable even while busy, dropped by a DONE clear.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_irq_en <= 1'b0;
        end else if (w_wr_status && avs.writedata[1] && !w_done_set) begin
            r_irq_en <= 1'b0;
        end else if (avs.write && (avs.address == 2'd1)) begin
            r_irq_en <= avs.writedata[10];
        end
    end

    assign w_irq_en_rd = r_irq_en;
    assign irq         = r_done && r_irq_en;
`else
    assign w_irq_en_rd = 1'b0;
`endif

    // Registered read mux, one cycle latency, no wait states.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            avs.readdata <= '0;
        end else begin
            case (avs.address)
                2'd0:    avs.readdata <= r_txdata;
                2'd1:    avs.readdata <= {21'd0, w_irq_en_rd, 1'b0, r_msb_first, 2'b00, r_nbits};
                2'd2:    avs.readdata <= {30'd0, r_done, w_busy};
                default: avs.readdata <= r_rxdata;
            endcase
        end
    end

endmodule

// File: tb/tb_lm96570_spi_master.sv
// Self-checking bench for lm96570_spi_master (CLK_DIV=2). Expected serial
// sequences, readback words and timings come from a bit-level reference
// model; define LM96570_SPI_IRQ_EN to also exercise the interrupt.
module tb_lm96570_spi_master;

    localparam int unsigned DIV = 2;

    logic clk = 1'b0;
    logic reset_n;
    logic spi_sclk, spi_sdi, spi_sle, spi_sdo;
    logic sdo_loop, sdo_const;
`ifdef LM96570_SPI_IRQ_EN
    logic irq;
`endif

    int n_checks = 0;
    int n_errors = 0;

    lm96570_spi_master_if bus ();

    assign spi_sdo = sdo_loop ? spi_sdi : sdo_const;

    lm96570_spi_master #(
        .CLK_DIV   (DIV),
        .SCLK_IDLE (0)
    ) dut (
        .clk      (clk),
        .reset_n  (reset_n),
        .avs      (bus.slave),
        .spi_sclk (spi_sclk),
        .spi_sdi  (spi_sdi),
        .spi_sle  (spi_sle),
        .spi_sdo  (spi_sdo)
`ifdef LM96570_SPI_IRQ_EN
        ,
        .irq      (irq)
`endif
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic bus_write(input logic [1:0] a, input logic [31:0] d);
        bus.address   = a;
        bus.writedata = d;
        bus.write     = 1'b1;
        tick();
        bus.write     = 1'b0;
    endtask

    task automatic bus_read(input logic [1:0] a, output logic [31:0] d);
        bus.address = a;
        tick();
        d = bus.readdata;
    endtask

    // Reference model
    function automatic int eff_n(input logic [5:0] nb);
        return (nb == 6'd0) ? 32 : int'(nb);
    endfunction

    function automatic logic [31:0] n_mask(input int n);
        return (n == 32) ? 32'hFFFF_FFFF : ((32'd1 << n) - 32'd1);
    endfunction

    // k-th bit placed on the wire (k = 0 is the first SCLK edge)
    function automatic logic wire_bit(input logic [31:0] tx, input int n, input logic msb, input int k);
        return msb ? tx[n - 1 - k] : tx[k];
    endfunction

    // One transfer, sampled every cycle: SDI at each SCLK rise, SLE width,
    // BUSY span from STATUS reads, then RXDATA. Optional mid-transfer
    // lockout writes and a DONE clear on the exact cycle DONE sets.
    task automatic run_transfer(input string tag, input logic [31:0] tx, input logic [5:0] nb,
                                input logic msb, input logic loop, input logic sdoc,
                                input logic lock, input logic clr_on_set);
        int n, t, first, last, sle_cnt, viol;
        logic finished, done_bit, prev_sclk, prev_sdi;
        logic [1:0] addr_prev;
        logic [31:0] obs_seq, exp_seq, rx;
        logic q[$];
        n = eff_n(nb);
        t = (2 * n + 1) * int'(DIV);
        first = -1; last = -1; sle_cnt = 0; viol = 0;
        finished = 1'b0; done_bit = 1'b0; prev_sclk = 1'b0; prev_sdi = 1'b0;
        sdo_loop  = loop;
        sdo_const = sdoc;
        bus_write(2'd0, tx);
        bus_write(2'd1, {22'd0, 1'b1, msb, 2'b00, nb});
        bus.address = 2'd2;
        addr_prev   = 2'd1;
        for (int cyc = 0; cyc < t + 20; cyc++) begin
            if (spi_sclk && !prev_sclk) q.push_back(spi_sdi);
            if (spi_sclk && prev_sclk && (spi_sdi !== prev_sdi)) viol++;
            if (spi_sle) sle_cnt++;
            if (spi_sle && spi_sclk) viol++;
            if (addr_prev == 2'd2) begin
                if (bus.readdata[0]) begin
                    if (first < 0) first = cyc;
                    last = cyc;
                end else if (first >= 0) begin
                    finished = 1'b1;
                    done_bit = bus.readdata[1];
                    break;
                end
            end
            if (lock && cyc == 4) begin
                bus.address = 2'd0; bus.writedata = 32'h1234_5678; bus.write = 1'b1;
            end else if (lock && cyc == 5) begin
                bus.address = 2'd1; bus.writedata = 32'h0000_0201; bus.write = 1'b1;
            end else if (lock && cyc == 6) begin
                bus.address = 2'd2; bus.write = 1'b0;
            end
            if (clr_on_set && cyc == t - 1) begin
                bus.writedata = 32'h2; bus.write = 1'b1;
            end else if (clr_on_set && cyc == t) begin
                bus.write = 1'b0;
            end
            addr_prev = bus.address;
            prev_sclk = spi_sclk;
            prev_sdi  = spi_sdi;
            tick();
        end
        bus.write = 1'b0;
        check_eq({tag, "_complete"}, 32'(finished), 32'd1);
        check_eq({tag, "_busy_cycles"}, 32'(last - first + 1), 32'(t));
        check_eq({tag, "_sclk_edges"}, 32'(q.size()), 32'(n));
        obs_seq = '0;
        exp_seq = '0;
        for (int k = 0; k < n; k++) begin
            if (k < q.size()) obs_seq[k] = q[k];
            exp_seq[k] = wire_bit(tx, n, msb, k);
        end
        check_eq({tag, "_sdi_seq"}, obs_seq, exp_seq);
        check_eq({tag, "_sle_cycles"}, 32'(sle_cnt), 32'(DIV));
        check_eq({tag, "_line_rules"}, 32'(viol), 32'd0);
        check_eq({tag, "_done"}, 32'(done_bit), 32'd1);
        bus_read(2'd3, rx);
        check_eq({tag, "_rxdata"}, rx, loop ? (tx & n_mask(n)) : (sdoc ? n_mask(n) : 32'd0));
    endtask

    initial begin : watchdog
        #2_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $display("Result: errors=%0d of %0d checks", n_errors + 1, n_checks + 1);
        $fatal(1);
    end

    initial begin : stim
        logic [31:0] d;
        logic [31:0] tx;
        logic [5:0]  nb;
        int          sle_seen;

        reset_n = 1'b0;
        bus.address = 2'd0; bus.write = 1'b0; bus.writedata = '0;
        sdo_loop = 1'b0; sdo_const = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_eq("rst_pins", {29'd0, spi_sclk, spi_sdi, spi_sle}, 32'd0);
        check_eq("rst_readdata", bus.readdata, 32'd0);
        @(negedge clk) reset_n = 1'b1;
        tick();
        bus_read(2'd2, d); check_eq("rst_status", d, 32'd0);
        bus_read(2'd3, d); check_eq("rst_rxdata", d, 32'd0);

        // CTRL fields read back; START never reads as 1
        bus_write(2'd1, 32'h0000_0505);
        bus_read(2'd1, d);
`ifdef LM96570_SPI_IRQ_EN
        check_eq("ctrl_readback", d, 32'h0000_0505);
`else
        check_eq("ctrl_readback", d, 32'h0000_0105);
`endif
        bus_write(2'd1, 32'h0);

        run_transfer("msb_a5", 32'h0000_00A5, 6'd8, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        run_transfer("lsb_loop32", 32'hDEAD_BEEF, 6'd0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        bus_read(2'd0, d); check_eq("txdata_readback", d, 32'hDEAD_BEEF);

        for (int i = 0; i < 6; i++) begin
            tx = $urandom;
            nb = 6'($urandom_range(0, 32));
            run_transfer("rand", tx, nb, 1'($urandom), 1'($urandom), 1'($urandom), 1'b0, 1'b0);
        end

        // Busy lockout: TXDATA write and START during a transfer are dropped
        run_transfer("lock", 32'hCAFE_F00D, 6'd12, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
        bus_read(2'd0, d); check_eq("lock_txdata", d, 32'hCAFE_F00D);
        bus_read(2'd1, d); check_eq("lock_ctrl", d, 32'h0000_010C);
        repeat (20) tick();
        bus_read(2'd2, d); check_eq("lock_single_xfer", d, 32'h2);

        // DONE clear after completion
        bus_write(2'd2, 32'h2);
        bus_read(2'd2, d); check_eq("done_clear", d, 32'h0);

        // Clear on the cycle DONE sets: set wins
        run_transfer("clr_race", 32'h0000_0F0F, 6'd5, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
        bus_read(2'd2, d); check_eq("clr_race_status", d, 32'h2);

        // Reset mid-transfer: lines drop at once, no SLE, registers cleared
        sdo_loop = 1'b0;
        sle_seen = 0;
        bus_write(2'd0, 32'hFFFF_FFFF);
        bus_write(2'd1, 32'h0000_0310);
        for (int c = 0; c < 10; c++) begin
            if (spi_sle) sle_seen++;
            tick();
        end
        #2 reset_n = 1'b0;
        #1;
        check_eq("midrst_pins", {29'd0, spi_sclk, spi_sdi, spi_sle}, 32'd0);
        @(negedge clk) reset_n = 1'b1;
        tick();
        for (int c = 0; c < 40; c++) begin
            if (spi_sle || spi_sclk) sle_seen++;
            tick();
        end
        check_eq("midrst_no_sle", 32'(sle_seen), 32'd0);
        bus_read(2'd2, d); check_eq("midrst_status", d, 32'd0);
        bus_read(2'd0, d); check_eq("midrst_txdata", d, 32'd0);

`ifdef LM96570_SPI_IRQ_EN
        begin : irq_test
            int rise;
            rise = -1;
            bus_write(2'd0, 32'h0000_0009);
            bus_write(2'd1, 32'h0000_0604);
            for (int c = 0; c < 100; c++) begin
                if (irq) begin
                    rise = c;
                    break;
                end
                tick();
            end
            check_eq("irq_rise_cycle", 32'(rise), 32'((2 * 4 + 1) * DIV));
            bus_read(2'd2, d); check_eq("irq_done", d, 32'h2);
            bus_write(2'd2, 32'h2);
            check_eq("irq_cleared", 32'(irq), 32'd0);
            bus_read(2'd1, d); check_eq("irq_en_cleared", d & 32'h400, 32'h0);
        end
`endif

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/lm96570_spi_master.md
Name: lm96570_spi_master

Overview:
- Avalon-MM slave SPI transmitter that programs the LM96570 beamformer's serial configuration interface (SCLK, SDI, SLE).
- Software loads a word, sets a bit count and issues start. The block shifts the word out, pulses SLE to latch it, and captures SDO for readback.
- Sits beside the existing SPI-readback PIO in the Qsys system. It is the write/transmit end of the same LM96570 serial link.

Parameters:
- CLK_DIV, 4, SCLK half-period in clk cycles; legal range 1..255.
- SCLK_IDLE, 0, SCLK level in IDLE and LATCH (fixed low; parameter kept for documentation; only 0 supported).

Ports:
- clk  in  1  system clock
- reset_n  in  1  asynchronous, active-low reset
- address  in  2  Avalon register select
- write  in  1  Avalon write strobe
- writedata  in  32  Avalon write data
- readdata  out  32  Avalon read data, registered
- spi_sclk  out  1  serial clock to LM96570
- spi_sdi  out  1  serial data to LM96570
- spi_sle  out  1  serial latch enable to LM96570
- spi_sdo  in  1  serial readback from LM96570 (synchronised internally, 2 flops)
- irq  out  1  completion interrupt (present only with LM96570_SPI_IRQ_EN)

Behaviour:
- Reset and clocking: reset_n is asynchronous, active-low; clk is the clock. Reset forces IDLE and clears all registers. Outputs at reset: readdata=0, spi_sclk=0, spi_sdi=0, spi_sle=0, irq=0.
- Register map:
  - addr0 TXDATA: R/W, 32 bits.
  - addr1 CTRL: [5:0] NBITS (0 means 32), [8] MSB_FIRST, [9] START (write-1 pulse, reads 0).
  - addr2 STATUS: [0] BUSY, [1] DONE (sticky; write 1 to bit1 clears it).
  - addr3 RXDATA: read-only, SDO bits captured.
- Read: readdata is updated every cycle from the addressed register. Latency 1 clk, no read strobe, no wait states.
- Busy lockout: while BUSY, writes to TXDATA and CTRL are ignored, including START. STATUS writes are still accepted.
- START in IDLE:
  - Copies TXDATA into the shift register and NBITS into the bit counter.
  - Clears RXDATA and DONE.
  - Enters SHIFT_LO on the next clk; BUSY=1 from that cycle.
- FSM states: IDLE, SHIFT_LO, SHIFT_HI, LATCH.
  - SHIFT_LO: spi_sclk=0. spi_sdi = current bit (bit[NBITS-1] first if MSB_FIRST, else bit0 first). Held CLK_DIV cycles, then -> SHIFT_HI.
  - SHIFT_HI: spi_sclk=1. The synchronised spi_sdo is sampled on the first cycle of SHIFT_HI and shifted into RXDATA in the same order as transmit. Held CLK_DIV cycles. Then: if bits remain, advance shift register and decrement counter, -> SHIFT_LO; else -> LATCH.
  - LATCH: spi_sclk=0, spi_sle=1 for CLK_DIV cycles. spi_sdi holds the last bit. Then -> IDLE: BUSY=0, DONE=1, spi_sle=0, spi_sdi=0.
- Timing: total BUSY duration = (2*N+1)*CLK_DIV cycles, N = effective bit count 1..32. spi_sdi changes only while spi_sclk is low.
- Divider: an 8-bit counter reloads on every state entry.
- Simultaneous events:
  - DONE set and STATUS clear-write in the same cycle: set wins.
  - START and DONE-clear in the same CTRL/STATUS write cannot collide (different addresses).
- Reset mid-transfer: lines return to idle immediately and asynchronously. No SLE pulse is issued, and the partial word is discarded.

Optional Feature:
- Macro LM96570_SPI_IRQ_EN.
- Defined: irq output exists and is high when STATUS.DONE=1 and CTRL[10] IRQ_EN=1. IRQ_EN is R/W and is not affected by the busy lockout; it is cleared by DONE clear or reset.
- Undefined: no irq port and CTRL[10] reads 0.

Test Plan:
- Reset: assert reset_n=0 mid-transfer (CLK_DIV=2, N=16, after 10 cycles) -> spi_sclk/sdi/sle=0 same cycle; STATUS reads 0 after release; no SLE pulse observed.
- MSB-first send: CLK_DIV=2, TXDATA=0x000000A5, CTRL=0x308 (N=8, MSB_FIRST, START) -> SDI sequence 1,0,1,0,0,1,0,1 on 8 SCLK rising edges; SLE high 2 cycles; BUSY duration 34 cycles; DONE=1.
- LSB-first loopback: spi_sdo tied to spi_sdi, TXDATA=0xDEADBEEF, N=0 (32), LSB-first -> 32 SCLK pulses; RXDATA reads 0xDEADBEEF; BUSY lasts 65*CLK_DIV cycles.
- Busy lockout: during a transfer write TXDATA=0x12345678 and CTRL START -> ignored; TXDATA unchanged and exactly one transfer completes.
- DONE clear: write STATUS=0x2 after completion -> DONE=0 next read. Write STATUS=0x2 on the cycle DONE sets -> DONE stays 1.
- IRQ (LM96570_SPI_IRQ_EN): CTRL IRQ_EN=1, N=4 transfer -> irq rises with DONE; STATUS clear -> irq low next cycle. Macro undefined -> no irq port.
